// File: rtl/cordic_hyp_rotation.sv
// Iterative hyperbolic CORDIC, rotation mode: cosh/sinh of Z0, one micro-rotation per clock.
// Optional EXP_OUT (X+Y = e^Z0) port is built when CORDIC_EXP_OUT_EN is defined.
module cordic_hyp_rotation #(
  parameter int WIDTH = 32,
  parameter int ITER  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] Z0,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] X_OUT,
  output logic [WIDTH-1:0] Y_OUT,
  output logic [WIDTH-1:0] Z_OUT,
  output logic             OOR
`ifdef CORDIC_EXP_OUT_EN
  ,
  output logic [WIDTH-1:0] EXP_OUT
`endif
);

  localparam int FRAC = 24;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ROT  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [WIDTH-1:0] KINV    = WIDTH'(20258439);
  localparam logic [WIDTH-1:0] OOR_LIM = WIDTH'(18759830);

  logic [1:0]              state;
  logic signed [WIDTH-1:0] x, y, z;
  logic signed [WIDTH-1:0] x_nx, y_nx, z_nx;
  logic signed [WIDTH-1:0] xs, ys, at;
  logic [4:0]              idx;
  logic                    rep;
  logic                    rep_pt;
  logic                    last;
  logic                    oor_q;
  logic                    done_q;
  logic [WIDTH-1:0]        z0_abs;
  logic                    oor_chk;
  logic [FRAC-1:0]         rom;

  always_comb begin
    rom = '0;
    case (idx)
      5'd1:  rom = 24'd9215828;
      5'd2:  rom = 24'd4285116;
      5'd3:  rom = 24'd2108178;
      5'd4:  rom = 24'd1049945;
      5'd5:  rom = 24'd524459;
      5'd6:  rom = 24'd262165;
      5'd7:  rom = 24'd131075;
      5'd8:  rom = 24'd65536;
      5'd9:  rom = 24'd32768;
      5'd10: rom = 24'd16384;
      5'd11: rom = 24'd8192;
      5'd12: rom = 24'd4096;
      5'd13: rom = 24'd2048;
      5'd14: rom = 24'd1024;
      5'd15: rom = 24'd512;
      5'd16: rom = 24'd256;
      5'd17: rom = 24'd128;
      5'd18: rom = 24'd64;
      5'd19: rom = 24'd32;
      5'd20: rom = 24'd16;
      5'd21: rom = 24'd8;
      5'd22: rom = 24'd4;
      5'd23: rom = 24'd2;
      5'd24: rom = 24'd1;
      default: rom = '0;
    endcase
  end

  assign at = signed'({{(WIDTH-FRAC){1'b0}}, rom});
  assign xs = y >>> idx;
  assign ys = x >>> idx;

  // Z = 0 rotates in the positive direction
  always_comb begin
    x_nx = x;
    y_nx = y;
    z_nx = z;
    if (!z[WIDTH-1]) begin
      x_nx = x + xs;
      y_nx = y + ys;
      z_nx = z - at;
    end else begin
      x_nx = x - xs;
      y_nx = y - ys;
      z_nx = z + at;
    end
  end

  assign rep_pt  = (idx == 5'd4) || ((ITER >= 13) && (idx == 5'd13));
  assign last    = (idx == 5'(ITER)) && !(rep_pt && !rep);
  assign z0_abs  = Z0[WIDTH-1] ? (~Z0 + 1'b1) : Z0;
  assign oor_chk = z0_abs > OOR_LIM;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      z      <= '0;
      idx    <= '0;
      rep    <= 1'b0;
      oor_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef CORDIC_EXP_OUT_EN
      EXP_OUT <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            x     <= KINV;
            y     <= '0;
            z     <= Z0;
            idx   <= 5'd1;
            rep   <= 1'b0;
            oor_q <= oor_chk;
            state <= ROT;
          end
        end
        ROT: begin
          x <= x_nx;
          y <= y_nx;
          z <= z_nx;
          if (rep_pt && !rep) begin
            rep <= 1'b1;
          end else begin
            rep <= 1'b0;
            idx <= idx + 5'd1;
          end
          if (last) begin
            state <= FIN;
`ifdef CORDIC_EXP_OUT_EN
            EXP_OUT <= x_nx + y_nx;
`endif
          end
        end
        FIN: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign READY = (state == IDLE);
  assign DONE  = done_q;
  assign X_OUT = x;
  assign Y_OUT = y;
  assign Z_OUT = z;
  assign OOR   = oor_q;

endmodule

// File: doc/cordic_hyp_rotation.md
Name: cordic_hyp_rotation

Overview:
- Iterative hyperbolic CORDIC in rotation mode. It drives the angle Z to zero using the sign of Z, and produces cosh(Z0) on X and sinh(Z0) on Y.
- It is the opposite direction of the logarithm datapath's vectoring mode, which drives Y to zero using the sign of Y. Together they give the exponential path of the natural-log/exp unit.
- Fixed-point, one micro-rotation per clock, START/DONE handshake to the FPU sequencer.

Parameters:
- WIDTH, 32, two's-complement datapath width of X, Y and Z. Legal range 28..40. Fraction is fixed at 24 bits (FRAC = 24, localparam).
- ITER, 16, highest shift index i. Legal range 8..24. Index 4 is always repeated; index 13 is repeated when ITER >= 13.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-low.
- START  input  1  request. Sampled only in IDLE.
- Z0  input  WIDTH  input angle, signed, 24 fraction bits.
- READY  output  1  high in IDLE.
- DONE  output  1  one-cycle completion pulse.
- X_OUT  output  WIDTH  cosh(Z0), signed, 24 fraction bits.
- Y_OUT  output  WIDTH  sinh(Z0), signed, 24 fraction bits.
- Z_OUT  output  WIDTH  residual angle, approximately 0.
- OOR  output  1  |Z0| > 1.118173 (outside the convergence range). Latched at START, held until next START.

Behaviour:
- Reset (asynchronous, RST = 0):
  - state = IDLE.
  - X, Y, Z, i counter, repeat flag, OOR = 0; DONE = 0; READY = 1.
- States: IDLE -> ROT -> FIN -> IDLE.
- IDLE:
  - START = 1 at an edge loads X = KINV, Y = 0, Z = Z0, i = 1, repeat flag = 0, OOR = range check of Z0; state -> ROT.
  - KINV = round(1.2074970677 * 2^24) = 1/K_h.
- ROT, one micro-rotation per edge:
  - d = +1 if Z[WIDTH-1] = 0, else d = -1. Z = 0 counts as positive.
  - X <= X + d*(Y >>> i)
  - Y <= Y + d*(X >>> i)
  - Z <= Z - d*ATANH[i]
  - >>> is an arithmetic shift. All updates use old values (simultaneous).
  - ATANH[i] = round(atanh(2^-i) * 2^24), i = 1..24, held in a case ROM, sign-extended to WIDTH.
  - Repeat rule: when i is 4, or 13 with ITER >= 13, and the repeat flag is 0, set the repeat flag and keep i. Otherwise clear the flag and increment i.
  - After the micro-rotation with i = ITER (and its repeat done, if applicable), state -> FIN.
  - M = ITER + number of repeated indices ≤ ITER. For ITER = 16, M = 18.
- FIN: DONE = 1 for exactly one cycle; state -> IDLE.
- Latency: START sampled at edge 0; DONE is high in the cycle after edge M+1. Next START is accepted at edge M+2 at the earliest.
- READY = (state == IDLE).
- START outside IDLE is ignored; no queuing.
- Outputs:
  - X_OUT, Y_OUT, Z_OUT are the working registers.
  - Valid from DONE until the next accepted START. During ROT they change every cycle.
- Arithmetic wraps modulo 2^WIDTH; no saturation.
- When OOR = 1, results are numerically unspecified but deterministic, and DONE still fires.
- Reset asserted mid-ROT aborts the operation immediately; no DONE is produced.

Optional Feature:
- Macro: CORDIC_EXP_OUT_EN.
- When defined:
  - Extra port EXP_OUT, output, WIDTH, equal to X + Y (e^Z0), registered on entry to FIN.
  - Reset value 0; held until the next FIN.
- When undefined: the port and its register are absent. All other timing is identical.

Test Plan:
- Reset: RST low mid-ROT, e.g. 5 cycles after START -> immediately READY = 1, DONE = 0, X/Y/Z/OOR = 0. No DONE appears afterwards.
- Z0 = 0x00000000 -> DONE exactly 19 cycles after the START edge (ITER = 16). X_OUT ≈ 1.0 and Y_OUT ≈ 0, each within ±2^-14. READY low throughout the operation.
- Z0 = 0.5 (0x00800000) -> X_OUT ≈ 1.127626 and Y_OUT ≈ 0.521095, within ±2^-14; |Z_OUT| < 2^-14; OOR = 0.
- Z0 = -1.0 (0xFF000000) -> X_OUT ≈ 1.543081 and Y_OUT ≈ -1.175201, within ±2^-14. With CORDIC_EXP_OUT_EN, EXP_OUT ≈ 0.367879.
- Z0 = 1.5 (0x01800000) -> OOR = 1 and DONE still fires. A START pulsed in the 3rd ROT cycle is ignored: exactly one DONE, and results match a clean run.
- Back-to-back: START held high continuously with Z0 = 0.25 -> a new operation is accepted every M+2 = 20 cycles. Each DONE gives X_OUT ≈ 1.031413 and Y_OUT ≈ 0.252612.
